// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the execute stage: M-extension op codes, the
// multiply/divide sequencer state encoding, and the ALU/branch op codes.
package mdu_seq_pkg;

  localparam logic [2:0] MDU_OP_MUL    = 3'd0;
  localparam logic [2:0] MDU_OP_MULH   = 3'd1;
  localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
  localparam logic [2:0] MDU_OP_MULHU  = 3'd3;
  localparam logic [2:0] MDU_OP_DIV    = 3'd4;
  localparam logic [2:0] MDU_OP_DIVU   = 3'd5;
  localparam logic [2:0] MDU_OP_REM    = 3'd6;
  localparam logic [2:0] MDU_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } br_op_e;

  // The divide/remainder group occupies the upper half of the encoding.
  function automatic logic is_div_op(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Unsigned iterative datapath shared by multiply and divide.
// hi/lo hold the running product (shift-add) or remainder/quotient
// (restoring shift-subtract); opb holds multiplicand or divisor.
module mdu_core
  import mdu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a_mag,
  input  logic [DATA_WIDTH-1:0] b_mag,
  output logic [DATA_WIDTH-1:0] hi_nxt,
  output logic [DATA_WIDTH-1:0] lo_nxt
);

  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [DATA_WIDTH:0]   sum, shifted, diff;

  // One iteration of either algorithm, exposed so the sequencer can fix up
  // the final value on the same edge that the last step is taken.
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, opb_q};
    shifted = {hi_q, lo_q[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    hi_nxt  = hi_q;
    lo_nxt  = lo_q;
    if (is_div) begin
      if (!diff[DATA_WIDTH]) begin
        hi_nxt = diff[DATA_WIDTH-1:0];
        lo_nxt = {lo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[DATA_WIDTH-1:0];
        lo_nxt = {lo_q[DATA_WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      hi_nxt = sum[DATA_WIDTH:1];
      lo_nxt = {sum[0], lo_q[DATA_WIDTH-1:1]};
    end else begin
      hi_nxt = {1'b0, hi_q[DATA_WIDTH-1:1]};
      lo_nxt = {hi_q[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  // Load operands on init (same layout for both algorithms), else advance.
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    opb_d = opb_q;
    if (init) begin
      hi_d  = '0;
      lo_d  = a_mag;
      opb_d = b_mag;
    end else if (step) begin
      hi_d = hi_nxt;
      lo_d = lo_nxt;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      opb_q <= opb_d;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer: handshake, FSM, iteration counter,
// divide special cases and sign fix-up around the unsigned mdu_core.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ITER       = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  stall_req
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  mdu_state_e              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [2:0]              op_q, op_d;
  logic                    neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag, hi_nxt, lo_nxt, quo_fix, rem_fix, fix_result;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic a_signed, b_signed, a_neg, b_neg, is_rem_in, div_zero, div_ovf;
  logic core_init, core_step;

  mdu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .init   (core_init),
    .step   (core_step),
    .is_div (is_div_op(op_q)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Decode the incoming op: signedness, magnitudes and divide special cases.
  always_comb begin
    a_signed  = (op == MDU_OP_MUL) || (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
                (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    b_signed  = (op == MDU_OP_MUL) || (op == MDU_OP_MULH) ||
                (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    is_rem_in = (op == MDU_OP_REM) || (op == MDU_OP_REMU);
    a_neg     = a_signed && src_a[DATA_WIDTH-1];
    b_neg     = b_signed && src_b[DATA_WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
    div_zero  = is_div_op(op) && (src_b == '0);
    div_ovf   = ((op == MDU_OP_DIV) || (op == MDU_OP_REM)) &&
                (src_a == MOST_NEG) && (src_b == '1);
  end

  // Sign correction of the final core step and selection of the result half.
  always_comb begin
    prod_fix = neg_res_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    quo_fix  = neg_res_q ? -lo_nxt : lo_nxt;
    rem_fix  = neg_rem_q ? -hi_nxt : hi_nxt;
    case (op_q)
      MDU_OP_MUL:                              fix_result = prod_fix[DATA_WIDTH-1:0];
      MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU: fix_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      MDU_OP_DIV, MDU_OP_DIVU:                 fix_result = quo_fix;
      default:                                 fix_result = rem_fix;
    endcase
  end

  // Next-state, handshake and stall logic; flush always wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    core_init = 1'b0;
    core_step = 1'b0;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d      = op;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          if (div_zero) begin
            result_d = is_rem_in ? src_a : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = is_rem_in ? '0 : MOST_NEG;
            state_d  = DONE;
          end else begin
            core_init = 1'b1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          core_step = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            result_d = fix_result;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall_req = ((state_q == IDLE) ? in_valid : 1'b1) && !(out_valid && out_ready);
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus pushes expected results and their
// due cycle; a negedge monitor checks every presented output.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, stall_req;
  logic [2:0]   op = '0;
  logic [W-1:0] src_a = '0, src_b = '0, result;
  int           cyc = 0, n_cmp = 0, n_bad = 0;
  bit           seen = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    int           due;
    string        name;
  } exp_t;
  exp_t exp_q[$];

  mdu_seq #(.DATA_WIDTH(W), .ITER(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Monitor: latency on first presentation, result and stall every DONE cycle.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_out_valid: got result %h, required no output (cycle %0d)", result, cyc);
      end else begin
        if (!seen) begin
          checkOutput({exp_q[0].name, "_latency"}, W'(cyc), W'(exp_q[0].due));
          seen = 1'b1;
        end
        checkOutput({exp_q[0].name, "_result"}, result, exp_q[0].res);
        checkOutput({exp_q[0].name, "_stall_done"}, W'(stall_req), W'(!out_ready));
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res, input int lat, input string name,
                               output int t_acc);
    int guard = 0;
    @(posedge clk); #1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s_wait_ready: got in_ready 0 after %0d cycles, required 1", name, guard);
    end
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    t_acc    = cyc;
    if (lat > 0) exp_q.push_back('{res, cyc + lat, name});
    #3;
    checkOutput({name, "_stall_accept"}, W'(stall_req), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    op       = 3'($urandom);
    src_a    = $urandom;
    src_b    = $urandom;
  endtask

  task automatic waitDrain(input string name);
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s_drain: got %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion by %0t, required $finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int g;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", W'(in_ready), W'(1));
    checkOutput("reset_out_valid", W'(out_valid), W'(0));
    checkOutput("reset_stall", W'(stall_req), W'(0));
    checkOutput("reset_result", result, W'(0));
    rst = 1'b0;

    // MUL 7 * -3 with the stall profile through CALC
    applyStimulus(MDU_OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7x-3", t);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      checkOutput("mul_stall_calc", W'(stall_req), W'(1));
    end

    applyStimulus(MDU_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max", t);
    applyStimulus(MDU_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min", t);
    applyStimulus(MDU_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1", t);
    applyStimulus(MDU_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh_m1", t);
    applyStimulus(MDU_OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33, "mul_shift", t);
    applyStimulus(MDU_OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_-7_2", t);
    applyStimulus(MDU_OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_-7_2", t);
    applyStimulus(MDU_OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_-2", t);
    applyStimulus(MDU_OP_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33, "rem_7_-2", t);
    applyStimulus(MDU_OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "divu_big", t);
    applyStimulus(MDU_OP_REMU,   32'd100,       32'd7,         32'd2,         33, "remu_100_7", t);
    applyStimulus(MDU_OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by0", t);
    applyStimulus(MDU_OP_REMU,   32'd5,         32'd0,         32'd5,         1,  "remu_by0", t);
    applyStimulus(MDU_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf", t);
    applyStimulus(MDU_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf", t);
    waitDrain("directed");

    // Back-pressure: out_ready low for three DONE cycles
    out_ready = 1'b0;
    applyStimulus(MDU_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_hold", t);
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold_idle_in_ready", W'(in_ready), W'(1));
    checkOutput("hold_idle_out_valid", W'(out_valid), W'(0));
    waitDrain("hold");

    // Flush ten cycles into a DIV, then accept a new op immediately
    applyStimulus(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, "div_flushed", t);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_in_ready", W'(in_ready), W'(1));
    checkOutput("flush_out_valid", W'(out_valid), W'(0));
    in_valid = 1'b1;
    op       = MDU_OP_DIVU;
    src_a    = 32'd100;
    src_b    = 32'd7;
    exp_q.push_back('{32'd14, cyc + 33, "divu_after_flush"});
    @(posedge clk); #1;
    checkOutput("flush_new_accept", W'(in_ready), W'(0));
    in_valid = 1'b0;
    waitDrain("flush");

    // Reset in the middle of a multiply must drop it silently
    applyStimulus(MDU_OP_MUL, 32'd3, 32'd5, 32'd0, 0, "mul_reset", t);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset_in_ready", W'(in_ready), W'(1));
    checkOutput("midreset_out_valid", W'(out_valid), W'(0));
    checkOutput("midreset_stall", W'(stall_req), W'(0));
    checkOutput("midreset_result", result, W'(0));
    repeat (40) @(posedge clk);
    #1;

    applyStimulus(MDU_OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, "mulhu_after_reset", t);
    waitDrain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
